// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Single-word core port with byte enables; whole-block memory port.
module dcache_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int SETS        = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ren,
  input  logic                      wen,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [3:0]                byte_select_vector,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata,
  output logic                      stall,
  output logic                      mem_ren,
  output logic                      mem_wen,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [32*BLOCK_WORDS-1:0] mem_wdata,
  input  logic [32*BLOCK_WORDS-1:0] mem_rdata,
  input  logic                      mem_ready,
  output logic [31:0]               miss_count,
  output logic [1:0]                state_dbg
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int LOW_W = 2 + OFF_W;
  localparam int TAG_W = ADDR_W - LOW_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [SETS-1:0]   dirty_q, dirty_d;
  logic [31:0]       miss_count_q, miss_count_d;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [TAG_W-1:0]  tag_d  [SETS];
  logic [31:0]       data_q [SETS][BLOCK_WORDS];
  logic [31:0]       data_d [SETS][BLOCK_WORDS];

  logic [OFF_W-1:0]  word_sel;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              req;
  logic              hit;
  logic              unused_byte_offset;

  assign word_sel           = addr[2 +: OFF_W];
  assign idx                = addr[LOW_W +: IDX_W];
  assign tag                = addr[ADDR_W-1 -: TAG_W];
  assign unused_byte_offset = ^addr[1:0];

  assign req        = ren | wen;
  assign hit        = req & valid_q[idx] & (tag_q[idx] == tag) & (state_q == IDLE);
  assign stall      = req & ~hit;
  assign rdata      = (ren && hit) ? data_q[idx][word_sel] : 32'd0;
  assign miss_count = miss_count_q;
  assign state_dbg  = state_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    miss_count_d = miss_count_q;
    tag_d        = tag_q;
    data_d       = data_q;
    mem_ren      = 1'b0;
    mem_wen      = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state_q)
      IDLE: begin
        // A store hit (including ren+wen) merges only the enabled lanes.
        if (stall) begin
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
        end else if (wen && hit) begin
          for (int b = 0; b < 4; b++) begin
            if (byte_select_vector[b]) begin
              data_d[idx][word_sel][8*b +: 8] = wdata[8*b +: 8];
            end
          end
          dirty_d[idx] = 1'b1;
        end
      end
      WRITEBACK: begin
        mem_wen  = 1'b1;
        mem_addr = {tag_q[idx], idx, {LOW_W{1'b0}}};
        for (int w = 0; w < BLOCK_WORDS; w++) begin
          mem_wdata[32*w +: 32] = data_q[idx][w];
        end
        if (mem_ready) begin
          dirty_d[idx] = 1'b0;
          state_d      = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_ren  = 1'b1;
        mem_addr = {addr[ADDR_W-1:LOW_W], {LOW_W{1'b0}}};
        if (mem_ready) begin
          for (int w = 0; w < BLOCK_WORDS; w++) begin
            data_d[idx][w] = mem_rdata[32*w +: 32];
          end
          tag_d[idx]   = tag;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          miss_count_d = miss_count_q + 32'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      miss_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed loads/stores with a scripted
// memory responder; memory requests and load hits are checked by a monitor.
module tb_dcache_ctrl;
  localparam int AW   = 32;
  localparam int SETS = 32;
  localparam int BW   = 4;
  localparam int EW   = 2 + 32 + 128;
  localparam logic [1:0] K_WB = 2'd1;
  localparam logic [1:0] K_AL = 2'd2;
  localparam logic [1:0] K_RD = 2'd3;

  logic          clock;
  logic          reset;
  logic          ren;
  logic          wen;
  logic [31:0]   addr;
  logic [3:0]    byte_select_vector;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          stall;
  logic          mem_ren;
  logic          mem_wen;
  logic [31:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata;
  logic          mem_ready;
  logic [31:0]   miss_count;
  logic [1:0]    state_dbg;

  dcache_ctrl #(.ADDR_W(AW), .SETS(SETS), .BLOCK_WORDS(BW)) dut (
    .clock(clock), .reset(reset), .ren(ren), .wen(wen), .addr(addr),
    .byte_select_vector(byte_select_vector), .wdata(wdata), .rdata(rdata),
    .stall(stall), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .miss_count(miss_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int errors  = 0;
  logic [EW-1:0] exp_q[$];
  logic          prev_ren = 1'b0;
  logic          prev_wen = 1'b0;
  logic [31:0]   held_addr = '0;
  logic [127:0]  held_data = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(input logic [1:0] k, input logic [31:0] a,
                                        input logic [127:0] d);
    return {k, a, d};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (reset) begin
      check("mem_exclusive", 128'(mem_ren & mem_wen), 128'd0);
      if (mem_wen && !prev_wen) begin
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_wb: got addr %h expected no request", mem_addr);
        end else begin
          e = exp_q.pop_front();
          check("wb_kind", 128'(K_WB), 128'(e[161:160]));
          check("wb_addr", 128'(mem_addr), 128'(e[159:128]));
          check("wb_data", mem_wdata, e[127:0]);
          held_addr = e[159:128];
          held_data = e[127:0];
        end
      end else if (mem_wen) begin
        check("wb_addr_hold", 128'(mem_addr), 128'(held_addr));
        check("wb_data_hold", mem_wdata, held_data);
        check("wb_stall", 128'(stall), 128'd1);
      end
      if (mem_ren && !prev_ren) begin
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_alloc: got addr %h expected no request", mem_addr);
        end else begin
          e = exp_q.pop_front();
          check("al_kind", 128'(K_AL), 128'(e[161:160]));
          check("al_addr", 128'(mem_addr), 128'(e[159:128]));
          held_addr = e[159:128];
        end
      end else if (mem_ren) begin
        check("al_addr_hold", 128'(mem_addr), 128'(held_addr));
        check("al_stall", 128'(stall), 128'd1);
      end
      if (ren && !wen && !stall) begin
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_load: got rdata %h expected no load", rdata);
        end else begin
          e = exp_q.pop_front();
          check("rd_kind", 128'(K_RD), 128'(e[161:160]));
          check("rd_data", 128'(rdata), 128'(e[31:0]));
        end
      end
    end
    prev_ren = mem_ren;
    prev_wen = mem_wen;
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] d);
    @(posedge clock); #1;
    ren = r; wen = w; addr = a; byte_select_vector = be; wdata = d;
  endtask

  task automatic clear_req();
    @(posedge clock); #1;
    ren = 1'b0; wen = 1'b0;
  endtask

  task automatic wait_hit();
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!stall) break;
    end
    check("hit_timeout", 128'(stall), 128'd0);
  endtask

  task automatic wait_mem_req();
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (mem_ren || mem_wen) break;
    end
    check("mem_req_timeout", 128'(mem_ren | mem_wen), 128'd1);
  endtask

  task automatic mem_respond(input int delay, input logic [127:0] blk);
    wait_mem_req();
    repeat (delay) @(posedge clock);
    @(posedge clock); #1;
    mem_ready = 1'b1; mem_rdata = blk;
    @(posedge clock); #1;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic load_hit(input logic [31:0] a, input logic [31:0] exp_word);
    exp_q.push_back(ent(K_RD, 32'd0, 128'(exp_word)));
    set_req(1'b1, 1'b0, a, 4'b0000, 32'd0);
    wait_hit();
    clear_req();
  endtask

  task automatic store_hit(input logic r, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d);
    set_req(r, 1'b1, a, be, d);
    wait_hit();
    check("store_no_mem", 128'({mem_ren, mem_wen}), 128'd0);
    clear_req();
  endtask

  // ---------------- stimulus ----------------
  logic [127:0] blk_a, blk_a2, blk_b, blk_c, blk_c2, blk_d, blk_e;

  initial begin
    blk_a  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    blk_a2 = {32'h3333_3333, 32'hAB22_2222, 32'h1111_1111, 32'hDEAD_CAFE};
    blk_b  = {32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777};
    blk_c  = {32'h0C0C_0C0C, 32'h0B0B_0B0B, 32'h0A0A_0A0A, 32'h0909_0909};
    blk_c2 = {32'h0C0C_0C0C, 32'h0B0B_0B0B, 32'h0A55_0A0A, 32'h0909_0909};
    blk_d  = {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0};
    blk_e  = {32'hE3E3_E3E3, 32'hE2E2_E2E2, 32'hE1E1_E1E1, 32'hE0E0_E0E0};

    reset = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0;
    byte_select_vector = '0; wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_stall", 128'(stall), 128'd0);
    check("reset_mem_req", 128'({mem_ren, mem_wen}), 128'd0);
    check("reset_rdata", 128'(rdata), 128'd0);
    check("reset_miss_count", 128'(miss_count), 128'd0);
    @(posedge clock); #1 reset = 1'b1;

    // cold load miss
    exp_q.push_back(ent(K_AL, 32'h100, 128'd0));
    exp_q.push_back(ent(K_RD, 32'd0, 128'(32'hDEAD_BEEF)));
    set_req(1'b1, 1'b0, 32'h100, 4'b0000, 32'd0);
    @(negedge clock);
    check("cold_stall", 128'(stall), 128'd1);
    check("cold_rdata", 128'(rdata), 128'd0);
    mem_respond(0, blk_a);
    wait_hit();
    check("miss_count_1", 128'(miss_count), 128'd1);
    clear_req();
    load_hit(32'h104, 32'h1111_1111);

    // store hits, partial lanes
    store_hit(1'b0, 32'h100, 4'b0011, 32'h0000_CAFE);
    load_hit(32'h100, 32'hDEAD_CAFE);
    store_hit(1'b0, 32'h108, 4'b1000, 32'hAB00_0000);
    load_hit(32'h108, 32'hAB22_2222);

    // dirty eviction: conflicting tag at the same index
    exp_q.push_back(ent(K_WB, 32'h100, blk_a2));
    exp_q.push_back(ent(K_AL, 32'h300, 128'd0));
    exp_q.push_back(ent(K_RD, 32'd0, 128'(32'h7777_7777)));
    set_req(1'b1, 1'b0, 32'h300, 4'b0000, 32'd0);
    mem_respond(0, 128'd0);
    mem_respond(0, blk_b);
    wait_hit();
    check("miss_count_2", 128'(miss_count), 128'd2);
    clear_req();

    // clean eviction: allocate only
    exp_q.push_back(ent(K_AL, 32'h100, 128'd0));
    exp_q.push_back(ent(K_RD, 32'd0, 128'(32'hDEAD_CAFE)));
    set_req(1'b1, 1'b0, 32'h100, 4'b0000, 32'd0);
    mem_respond(0, blk_a2);
    wait_hit();
    check("miss_count_3", 128'(miss_count), 128'd3);
    clear_req();

    // store miss: allocate then merge
    exp_q.push_back(ent(K_AL, 32'h400, 128'd0));
    set_req(1'b0, 1'b1, 32'h404, 4'b0100, 32'h0055_0000);
    mem_respond(0, blk_c);
    wait_hit();
    check("store_miss_no_mem", 128'({mem_ren, mem_wen}), 128'd0);
    clear_req();
    load_hit(32'h404, 32'h0A55_0A0A);
    check("miss_count_4", 128'(miss_count), 128'd4);

    // delayed memory on both writeback and allocate
    exp_q.push_back(ent(K_WB, 32'h400, blk_c2));
    exp_q.push_back(ent(K_AL, 32'h600, 128'd0));
    exp_q.push_back(ent(K_RD, 32'd0, 128'(32'hD0D0_D0D0)));
    set_req(1'b1, 1'b0, 32'h600, 4'b0000, 32'd0);
    mem_respond(10, 128'd0);
    mem_respond(10, blk_d);
    wait_hit();
    check("miss_count_5", 128'(miss_count), 128'd5);
    clear_req();

    // ren and wen together behave as a store
    store_hit(1'b1, 32'h60C, 4'b0001, 32'h0000_00EE);
    load_hit(32'h60C, 32'hD3D3_D3EE);

    // stray mem_ready in IDLE is ignored
    @(posedge clock); #1 mem_ready = 1'b1;
    @(posedge clock); #1 mem_ready = 1'b0;
    @(negedge clock);
    check("idle_ready_miss_count", 128'(miss_count), 128'd5);
    check("idle_ready_mem_req", 128'({mem_ren, mem_wen}), 128'd0);
    load_hit(32'h600, 32'hD0D0_D0D0);

    // reset in the middle of an allocate
    exp_q.push_back(ent(K_AL, 32'h810, 128'd0));
    set_req(1'b1, 1'b0, 32'h810, 4'b0000, 32'd0);
    wait_mem_req();
    @(posedge clock); #3 reset = 1'b0;
    #1;
    check("midreset_mem_ren", 128'(mem_ren), 128'd0);
    check("midreset_mem_wen", 128'(mem_wen), 128'd0);
    check("midreset_miss_count", 128'(miss_count), 128'd0);
    exp_q.push_back(ent(K_AL, 32'h810, 128'd0));
    exp_q.push_back(ent(K_RD, 32'd0, 128'(32'hE0E0_E0E0)));
    @(posedge clock); #1 reset = 1'b1;
    mem_respond(0, blk_e);
    wait_hit();
    check("post_reset_miss_count", 128'(miss_count), 128'd1);
    clear_req();

    // lines valid before reset must miss again, with no writeback
    exp_q.push_back(ent(K_AL, 32'h100, 128'd0));
    exp_q.push_back(ent(K_RD, 32'd0, 128'(32'hDEAD_CAFE)));
    set_req(1'b1, 1'b0, 32'h100, 4'b0000, 32'd0);
    mem_respond(0, blk_a2);
    wait_hit();
    check("post_reset_miss_count_2", 128'(miss_count), 128'd2);
    clear_req();

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter SETS, default 32, number of direct-mapped lines (power of two).
REQ-003 SHALL have parameter BLOCK_WORDS, default 4, 32-bit words per line (power of two).
REQ-004 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ren  input  1  core load request.
REQ-007 SHALL have port wen  input  1  core store request.
REQ-008 SHALL have port addr  input  ADDR_W  core byte address.
REQ-009 SHALL have port byte_select_vector  input  4  store byte enables; bit i enables wdata[8i+7:8i].
REQ-010 SHALL have port wdata  input  32  store data, already lane-aligned.
REQ-011 SHALL have port rdata  output  32  load data (whole word).
REQ-012 SHALL have port stall  output  1  core must hold its request and freeze its pipeline.
REQ-013 SHALL have port mem_ren  output  1  block read request to memory.
REQ-014 SHALL have port mem_wen  output  1  block write request to memory.
REQ-015 SHALL have port mem_addr  output  ADDR_W  block-aligned memory address.
REQ-016 SHALL have port mem_wdata  output  32*BLOCK_WORDS  victim block, word 0 in LSBs.
REQ-017 SHALL have port mem_rdata  input  32*BLOCK_WORDS  fill block, word 0 in LSBs.
REQ-018 SHALL have port mem_ready  input  1  one-cycle completion pulse for the current memory request.
REQ-019 SHALL have port miss_count  output  32  number of completed allocations since reset.

Function
REQ-020 Address split: byte offset [1:0], word select next log2(BLOCK_WORDS) bits, index next log2(SETS) bits, tag the remaining upper bits.
REQ-021 Per line: valid bit, dirty bit, tag, BLOCK_WORDS data words.
REQ-022 hit = (ren or wen) and valid[index] and tag match and state IDLE.
REQ-023 stall SHALL be combinational: 1 whenever (ren or wen) and not hit; 0 otherwise.
REQ-024 Load hit: rdata = selected word in the same cycle, zero added latency; rdata = 0 when not (ren and hit).
REQ-025 Store hit: at the clock edge, write only the enabled byte lanes of the selected word and set dirty; no memory traffic.
REQ-026 ren and wen both high SHALL be treated as a store.
REQ-027 FSM states: IDLE, WRITEBACK, ALLOCATE.
REQ-028 IDLE, request misses, victim valid and dirty -> WRITEBACK; request misses, victim clean or invalid -> ALLOCATE; otherwise stay.
REQ-029 WRITEBACK: mem_wen=1, mem_addr = {victim tag, index, zeros}, mem_wdata = victim block, all held stable; on mem_ready -> ALLOCATE and clear dirty.
REQ-030 ALLOCATE: mem_ren=1, mem_addr = block-aligned request address, held stable; on mem_ready load mem_rdata into the line, write the tag, set valid=1 and dirty=0, increment miss_count, -> IDLE.
REQ-031 Request hits in IDLE on the cycle after the fill; a store then merges per REQ-025 (write-allocate, write-back).
REQ-032 mem_ren and mem_wen SHALL never be high together and SHALL be 0 in IDLE.
REQ-033 mem_ready SHALL be ignored in IDLE.
REQ-034 miss_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-035 Core keeps ren/wen/addr/wdata stable while stall=1; behaviour is undefined if the request changes mid-miss.

Reset
REQ-036 reset low SHALL immediately set state IDLE, clear all valid and dirty bits, zero miss_count, and deassert mem_ren/mem_wen, including mid-WRITEBACK or mid-ALLOCATE; data and tag arrays need not be cleared.
REQ-037 After reset, stall follows REQ-023, so any request misses; rdata = 0.

Verification
REQ-038 Cold load: ren=1, addr=0x100 -> stall=1, mem_ren=1, mem_addr=0x100; mem_ready with word0=0xDEADBEEF -> next cycle stall=0, rdata=0xDEADBEEF, miss_count=1.
REQ-039 Store hit: after REQ-038, wen=1, addr=0x100, byte_select_vector=0b0011, wdata=0x0000CAFE -> stall=0, no mem request; subsequent load returns 0xDEADCAFE.
REQ-040 Dirty eviction: after REQ-039, ren=1, addr=0x100+16*SETS -> WRITEBACK with mem_addr=0x100 and word0=0xDEADCAFE, then ALLOCATE with mem_addr=0x300 (defaults), then hit; miss_count=2.
REQ-041 Clean eviction: load two conflicting clean blocks -> no mem_wen pulse, ALLOCATE only.
REQ-042 Delayed memory: mem_ready delayed 10 cycles -> stall, mem_addr and mem_wdata stable for all 10 cycles.
REQ-043 Reset mid-ALLOCATE: reset low -> mem_ren=0 immediately; after release, same load misses again and miss_count restarts at 0.
